cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It generalises the fixed 64-bit carry-lookahead subtractor with configurable width, lookahead group size and pipeline depth. It adds a runtime add/sub mode and a valid/ready handshake. It sits in the datapath between operand registers and the result consumer, and exports word-level propagate/generate so the same borrow-out equation stays usable downstream.

Parameters:
WIDTH, 64, operand/result width; must be a multiple of GROUP.
GROUP, 4, bits per lookahead group (P/G computed per group, then combined hierarchically).
STAGES, 2, pipeline register stages (1..WIDTH/GROUP); carry chain cut only on group boundaries.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  synchronous reset, active low.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_sub  input  1  0 = add, 1 = subtract.
in_a  input  WIDTH  minuend/addend.
in_b  input  WIDTH  subtrahend/addend.
in_ci  input  1  carry-in (add) or borrow-in (sub).
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts result.
out_res  output  WIDTH  sum or difference.
out_co  output  1  carry-out (add) or borrow-out (sub).
out_gp  output  1  word propagate of (a, b') where b' = b (add) or ~b (sub).
out_gg  output  1  word generate of (a, b').

Behaviour:
- Reset: when rst_n = 0 at a clock edge, all stage valid bits clear, and out_valid, out_res, out_co, out_gp, out_gg become 0 the following cycle. In-flight beats are discarded and never appear at the output. in_ready is 1 during and after reset.
- Add: {out_co, out_res} = a + b + ci, computed at WIDTH+1 bits.
- Sub: internal b' = ~b, c0 = ~ci, c_W = gg | (gp & c0). out_co = ~c_W. Result: {out_co, out_res} = (a - b - ci) mod 2^(WIDTH+1), so borrow-out is 1 exactly when a < b + ci (unsigned).
- Add mode uses c0 = ci and out_co = c_W.
- out_gp/out_gg are always the raw lookahead terms, independent of ci, and are registered with the result beat.
- Pipeline advance enable: adv = out_ready | ~out_valid. in_ready = adv. All stages move together when adv = 1 and hold otherwise (whole-pipe stall; bubbles are not squeezed).
- Accept occurs when in_valid & in_ready. Each stage register carries a valid bit; the partial carry, operands and mode travel with the beat.
- Latency: exactly STAGES cycles from accept to out_valid when never stalled. Throughput is 1 beat/cycle.
- Output hold: while out_valid & ~out_ready, out_res/out_co/out_gp/out_gg/out_valid stay stable.
- Simultaneous output accept and new input: both happen in the same cycle at full rate.
- Beats remain in order; no reordering or dropping except on reset.
- in_valid = 0 with adv = 1 inserts a bubble (stage valid = 0). Data in invalid stages is don't-care, but out_res must not change while out_valid = 0 (clock-gate friendly).
- Mode may change every beat; mode is captured per beat at accept.

Optional Feature:
CLA_OVERFLOW_EN: when defined, adds output out_ovf (1 bit), registered with the beat. It is the signed two's-complement overflow, equal to c_W XOR c_(W-1) computed on (a, b', c0) in both modes. Reset value is 0. When undefined, the port and its logic are absent and the port list is exactly as above.

Test Plan:
- WIDTH=64, STAGES=2, sub, a=5, b=3, ci=1, out_ready=1 -> 2 cycles later out_valid=1, out_res=1, out_co=0.
- Sub, a=0, b=0, ci=1 -> out_res=0xFFFF_FFFF_FFFF_FFFF, out_co=1, out_gp=1, out_gg=0.
- Add, a=0xFFFF_FFFF_FFFF_FFFF, b=0, ci=1 -> out_res=0, out_co=1, out_gp=1, out_gg=0; repeat with ci=0 -> out_res=all ones, out_co=0.
- Three back-to-back beats (sub 10-4-0, add 1+1+0, sub 0-1-0), with out_ready=0 for 2 cycles once the first result is valid -> in_ready=0 and outputs stable during the stall. Results then arrive in order as 6/co0, 2/co0, 0xFFFF_FFFF_FFFF_FFFF/co1.
- Two beats in flight, rst_n=0 for one cycle -> out_valid=0 the next cycle. Neither beat ever appears, and a beat accepted after reset emerges with 2-cycle latency.
- With CLA_OVERFLOW_EN: add 0x7FFF_FFFF_FFFF_FFFF + 1 + 0 -> out_ovf=1. Sub 0x8000_0000_0000_0000 - 1 - 0 -> out_ovf=1. Sub 5-3-0 -> out_ovf=0.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Define CLA_OVERFLOW_EN to add the signed-overflow output out_ovf.
module cla_addsub_pipe #(
   parameter int WIDTH  = 64,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_co,
   output logic             out_gp,
`ifdef CLA_OVERFLOW_EN
   output logic             out_gg,
   output logic             out_ovf
`else
   output logic             out_gg
`endif
);
   localparam int NG = WIDTH / GROUP;
   localparam int L  = STAGES - 1;

   function automatic int grp_lo(input int s);
      return (s * NG) / STAGES;
   endfunction

   function automatic int stage_of(input int g);
      int r;
      r = 0;
      for (int s = 0; s < STAGES; s++) begin
         if (g >= grp_lo(s)) r = s;
      end
      return r;
   endfunction

   // Bits owned by stage s: the result slice that stage fills in.
   function automatic logic [WIDTH-1:0] stage_mask(input int s);
      logic [WIDTH:0] one;
      logic [WIDTH:0] m;
      one = {{WIDTH{1'b0}}, 1'b1};
      m   = (one << (grp_lo(s + 1) * GROUP)) - (one << (grp_lo(s) * GROUP));
      return m[WIDTH-1:0];
   endfunction

   logic             adv;
   logic [WIDTH-1:0] res_all;

   // Reset forces the pipe to advance so in_ready stays high while rst_n is low.
   assign adv      = ~rst_n | out_ready | ~out_valid;
   assign in_ready = adv;

   for (genvar si = 0; si < STAGES; si++) begin : stg
      localparam int               HI   = grp_lo(si + 1);
      localparam logic [WIDTH-1:0] MASK = stage_mask(si);

      logic             v_in, sub_in, c_in, gp_in, gg_in;
      logic [WIDTH-1:0] a_in, b_in, res_in;
      logic             c_d, gp_d, gg_d;
      logic [WIDTH-1:0] res_d;
      logic             v_q, sub_q, c_q, gp_q, gg_q;
      logic [WIDTH-1:0] res_q;

      if (si == 0) begin : g_head
         assign v_in   = in_valid;
         assign sub_in = in_sub;
         assign a_in   = in_a;
         assign b_in   = in_b ^ {WIDTH{in_sub}};
         assign c_in   = in_ci ^ in_sub;
         assign gp_in  = 1'b1;
         assign gg_in  = 1'b0;
         assign res_in = '0;
      end else begin : g_body
         assign v_in   = stg[si-1].v_q;
         assign sub_in = stg[si-1].sub_q;
         assign a_in   = stg[si-1].g_ab.a_q;
         assign b_in   = stg[si-1].g_ab.b_q;
         assign c_in   = stg[si-1].c_q;
         assign gp_in  = stg[si-1].gp_q;
         assign gg_in  = stg[si-1].gg_q;
         assign res_in = stg[si-1].res_q;
      end

      assign c_d   = grp[HI-1].c_out;
      assign gp_d  = grp[HI-1].gp_run;
      assign gg_d  = grp[HI-1].gg_run;
      assign res_d = (res_in & ~MASK) | (res_all & MASK);

      // Payload only loads with a valid beat so idle outputs never toggle.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            sub_q <= 1'b0;
            c_q   <= 1'b0;
            gp_q  <= 1'b0;
            gg_q  <= 1'b0;
            res_q <= '0;
         end else if (adv) begin
            v_q <= v_in;
            if (v_in) begin
               sub_q <= sub_in;
               c_q   <= c_d;
               gp_q  <= gp_d;
               gg_q  <= gg_d;
               res_q <= res_d;
            end
         end
      end

      if (si < STAGES - 1) begin : g_ab
         logic [WIDTH-1:0] a_q, b_q;
         always_ff @(posedge clk) begin
            if (adv && v_in) begin
               a_q <= a_in;
               b_q <= b_in;
            end
         end
      end
   end

   for (genvar gi = 0; gi < NG; gi++) begin : grp
      localparam int S     = stage_of(gi);
      localparam bit FIRST = (gi == grp_lo(S));

      logic [GROUP-1:0] a_g, b_g;
      logic             c_grp, gp_prev, gg_prev;
      logic             grp_p, grp_g, c_out, gp_run, gg_run;

      assign a_g = stg[S].a_in[gi*GROUP +: GROUP];
      assign b_g = stg[S].b_in[gi*GROUP +: GROUP];

      if (FIRST) begin : g_cin
         assign c_grp   = stg[S].c_in;
         assign gp_prev = stg[S].gp_in;
         assign gg_prev = stg[S].gg_in;
      end else begin : g_cin
         assign c_grp   = grp[gi-1].c_out;
         assign gp_prev = grp[gi-1].gp_run;
         assign gg_prev = grp[gi-1].gg_run;
      end

      // Each bit carry is formed directly from the group carry-in via prefix P/G.
      for (genvar bi = 0; bi < GROUP; bi++) begin : bit_l
         logic p, g, pp, gpre, ci;
         assign p = a_g[bi] ^ b_g[bi];
         assign g = a_g[bi] & b_g[bi];
         if (bi == 0) begin : g_first
            assign pp   = p;
            assign gpre = g;
            assign ci   = c_grp;
         end else begin : g_next
            assign pp   = bit_l[bi-1].pp & p;
            assign gpre = g | (p & bit_l[bi-1].gpre);
            assign ci   = bit_l[bi-1].gpre | (bit_l[bi-1].pp & c_grp);
         end
         assign res_all[gi*GROUP + bi] = p ^ ci;
      end

      assign grp_p  = bit_l[GROUP-1].pp;
      assign grp_g  = bit_l[GROUP-1].gpre;
      assign c_out  = grp_g | (grp_p & c_grp);
      assign gp_run = grp_p & gp_prev;
      assign gg_run = grp_g | (grp_p & gg_prev);
   end

   assign out_valid = stg[L].v_q;
   assign out_res   = stg[L].res_q;
   assign out_co    = stg[L].c_q ^ stg[L].sub_q;
   assign out_gp    = stg[L].gp_q;
   assign out_gg    = stg[L].gg_q;

`ifdef CLA_OVERFLOW_EN
   logic ovf_q;

   // Overflow is carry-out of the MSB against carry-in to the MSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv && stg[L].v_in) begin
         ovf_q <= grp[NG-1].c_out ^ grp[NG-1].bit_l[GROUP-1].ci;
      end
   end

   assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed-vector bench for cla_addsub_pipe (64-bit, 4-bit groups, 2 stages).
// Overflow vectors run only when CLA_OVERFLOW_EN is defined.
module tb_cla_addsub_pipe;
   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_sub;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_ci;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_res;
   logic          out_co;
   logic          out_gp;
   logic          out_gg;
`ifdef CLA_OVERFLOW_EN
   logic          out_ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   localparam logic [W-1:0] ONES = {W{1'b1}};

   always #5 clk = ~clk;

   cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sub    (in_sub),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_ci     (in_ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_co    (out_co),
      .out_gp    (out_gp),
`ifdef CLA_OVERFLOW_EN
      .out_gg    (out_gg),
      .out_ovf   (out_ovf)
`else
      .out_gg    (out_gg)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One beat through an empty pipe: no result after 1 cycle, result after 2.
   task automatic beat(input string tag, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci, input logic [W-1:0] e_res,
                       input logic e_co, input logic e_gp, input logic e_gg);
      in_sub = s; in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk1({tag, ".lat1"}, out_valid, 1'b0);
      tick();
      chk1({tag, ".valid"}, out_valid, 1'b1);
      chk ({tag, ".res"},   out_res,   e_res);
      chk1({tag, ".co"},    out_co,    e_co);
      chk1({tag, ".gp"},    out_gp,    e_gp);
      chk1({tag, ".gg"},    out_gg,    e_gg);
      $display("beat %s: sub=%0b a=%h b=%h ci=%0b -> res=%h co=%0b gp=%0b gg=%0b",
               tag, s, a, b, ci, out_res, out_co, out_gp, out_gg);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0;
      out_ready = 1'b1;
      #1;
      chk1("rst.ready_during", in_ready, 1'b1);
      tick();
      tick();
      chk1("rst.valid", out_valid, 1'b0);
      chk ("rst.res",   out_res,   '0);
      chk1("rst.co",    out_co,    1'b0);
      chk1("rst.gp",    out_gp,    1'b0);
      chk1("rst.gg",    out_gg,    1'b0);
      chk1("rst.ready", in_ready,  1'b1);
      rst_n = 1'b1;
      tick();
      chk1("post_rst.valid", out_valid, 1'b0);
      $display("reset released");

      beat("sub5_3_1",  1'b1, 64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0, 1'b1);
      beat("sub0_0_1",  1'b1, 64'd0, 64'd0, 1'b1, ONES,  1'b1, 1'b1, 1'b0);
      beat("addF_0_1",  1'b0, ONES,  64'd0, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0);
      beat("addF_0_0",  1'b0, ONES,  64'd0, 1'b0, ONES,  1'b0, 1'b1, 1'b0);
      beat("add_split", 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
           64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);

      // Back-to-back beats with a two-cycle output stall.
      in_valid = 1'b1; in_sub = 1'b1; in_a = 64'd10; in_b = 64'd4; in_ci = 1'b0;
      tick();
      in_sub = 1'b0; in_a = 64'd1; in_b = 64'd1; in_ci = 1'b0;
      tick();
      out_ready = 1'b0;
      in_sub = 1'b1; in_a = 64'd0; in_b = 64'd1; in_ci = 1'b0;
      #1;
      chk1("b2b.ready_stall", in_ready,  1'b0);
      chk1("b2b.A.valid",     out_valid, 1'b1);
      chk ("b2b.A.res",       out_res,   64'd6);
      chk1("b2b.A.co",        out_co,    1'b0);
      $display("b2b beat A: res=%h co=%0b (stall starts)", out_res, out_co);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk1("b2b.hold.ready", in_ready,  1'b0);
         chk1("b2b.hold.valid", out_valid, 1'b1);
         chk ("b2b.hold.res",   out_res,   64'd6);
         chk1("b2b.hold.co",    out_co,    1'b0);
         chk1("b2b.hold.gp",    out_gp,    1'b0);
         chk1("b2b.hold.gg",    out_gg,    1'b1);
         $display("b2b stall cycle %0d: res=%h held", k, out_res);
      end
      out_ready = 1'b1;
      #1;
      chk1("b2b.ready_resume", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk1("b2b.B.valid", out_valid, 1'b1);
      chk ("b2b.B.res",   out_res,   64'd2);
      chk1("b2b.B.co",    out_co,    1'b0);
      $display("b2b beat B: res=%h co=%0b", out_res, out_co);
      tick();
      chk1("b2b.C.valid", out_valid, 1'b1);
      chk ("b2b.C.res",   out_res,   ONES);
      chk1("b2b.C.co",    out_co,    1'b1);
      $display("b2b beat C: res=%h co=%0b", out_res, out_co);
      tick();
      chk1("b2b.bubble.valid", out_valid, 1'b0);
      chk ("b2b.bubble.res",   out_res,   ONES);
      $display("b2b bubble: res=%h held while idle", out_res);

      // Reset with beats in flight: neither may emerge.
      in_valid = 1'b1; in_sub = 1'b0; in_a = 64'h100; in_b = 64'h200; in_ci = 1'b0;
      tick();
      in_a = 64'h300; in_b = 64'h400;
      rst_n = 1'b0;
      #1;
      chk1("flush.ready_in_rst", in_ready, 1'b1);
      tick();
      rst_n = 1'b1; in_valid = 1'b0;
      chk1("flush.valid0", out_valid, 1'b0);
      chk ("flush.res0",   out_res,   '0);
      tick();
      chk1("flush.valid1", out_valid, 1'b0);
      tick();
      chk1("flush.valid2", out_valid, 1'b0);
      chk ("flush.res2",   out_res,   '0);
      $display("flush: in-flight beats discarded");
      beat("post_flush", 1'b0, 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);

`ifdef CLA_OVERFLOW_EN
      beat("ovf_add", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
      chk1("ovf_add.ovf", out_ovf, 1'b1);
      beat("ovf_sub", 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
      chk1("ovf_sub.ovf", out_ovf, 1'b1);
      beat("ovf_none", 1'b1, 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b1);
      chk1("ovf_none.ovf", out_ovf, 1'b0);
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
